// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, state encoding and entry type for the writeback arbiter
package regfile_pkg;

   localparam int REG_AW = 5;
   localparam int DATA_W = 32;
   localparam int NREGS  = 1 << REG_AW;

   // Arbiter priority states
   localparam logic [0:0] A_PRIO = 1'b0;
   localparam logic [0:0] B_PRIO = 1'b1;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   // Writes to x0 are architecturally discarded
   function automatic logic is_x0(input logic [REG_AW-1:0] r);
      return (r == '0);
   endfunction

endpackage

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - two-entry writeback queue with per-entry visibility
module wb_fifo2
   import regfile_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [REG_AW-1:0]            push_rd,
   input  logic [DATA_W-1:0]            push_data,
   input  logic                         pop,
   output logic                         full,
   output logic                         empty,
   output logic [REG_AW-1:0]            head_rd,
   output logic [DATA_W-1:0]            head_data,
   output logic [1:0]                   ent_valid,
   output logic [1:0][REG_AW-1:0]       ent_rd
);

   wb_entry_t  mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       push_ok;
   logic       pop_ok;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   // Push is refused when full even if a pop happens the same cycle, so
   // freed space only becomes visible to the producer one cycle later.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   assign head_rd   = mem[rd_ptr].rd;
   assign head_data = mem[rd_ptr].data;

   // Expose which slots hold live entries so the owner can build a scoreboard
   always_comb begin
      ent_valid = 2'b00;
      if (count == 2'd2) begin
         ent_valid = 2'b11;
      end else if (count == 2'd1) begin
         ent_valid[rd_ptr] = 1'b1;
      end
      ent_rd[0] = mem[0].rd;
      ent_rd[1] = mem[1].rd;
   end

   // Storage write and pointer/count bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= '{rd: push_rd, data: push_data};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - arbitrates core and long-latency writebacks onto one regfile port
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_valid,
   input  logic [REG_AW-1:0]    a_rd,
   input  logic [DATA_W-1:0]    a_data,
   output logic                 a_ready,
   input  logic                 b_valid,
   input  logic [REG_AW-1:0]    b_rd,
   input  logic [DATA_W-1:0]    b_data,
   output logic                 b_ready,
   output logic                 RegWrite,
   output logic [REG_AW-1:0]    rd,
   output logic [DATA_W-1:0]    WriteData,
   output logic [NREGS-1:0]     busy_mask
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [0:0]              state;
   logic [3:0]              age;
   logic [3:0]              age_next;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [REG_AW-1:0]       head_rd;
   logic [DATA_W-1:0]       head_data;
   logic [1:0]              ent_valid;
   logic [1:0][REG_AW-1:0]  ent_rd;
   logic                    b_push;
   logic                    waw_hit;
   logic                    head_grant;
   logic                    a_accept;

   wb_fifo2 u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (b_push),
      .push_rd   (b_rd),
      .push_data (b_data),
      .pop       (head_grant),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head_rd   (head_rd),
      .head_data (head_data),
      .ent_valid (ent_valid),
      .ent_rd    (ent_rd)
   );

   // Pending-B scoreboard; x0 can never be pending
   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < 2; i++) begin
         if (ent_valid[i]) begin
            busy_mask[ent_rd[i]] = 1'b1;
         end
      end
      busy_mask[0] = 1'b0;
   end

   assign b_ready  = !fifo_full;
   // x0 writes from B are acknowledged and dropped
   assign b_push   = b_valid && b_ready && !is_x0(b_rd);
   // A must not overtake an older queued write to the same register
   assign waw_hit  = a_valid && busy_mask[a_rd];
   assign a_ready  = (state == A_PRIO) && !waw_hit;
   assign a_accept = a_valid && a_ready;
   assign age_next = age + 4'd1;

   // Head grant: forced by a WAW hazard or starvation, else only when A is idle
   always_comb begin
      head_grant = 1'b0;
      if (!fifo_empty) begin
         if (waw_hit || state == B_PRIO) begin
            head_grant = 1'b1;
         end else if (!a_valid) begin
            head_grant = 1'b1;
         end
      end
   end

   // Priority FSM with starvation age counter for the queued head
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= A_PRIO;
         age   <= 4'd0;
      end else if (state == B_PRIO) begin
         state <= A_PRIO;
         age   <= 4'd0;
      end else if (fifo_empty || head_grant) begin
         age   <= 4'd0;
      end else begin
         age <= age_next;
         if (age_next == STARVE_LIM) begin
            state <= B_PRIO;
         end
      end
   end

   // Registered write port; rd/WriteData hold when nothing is issued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWrite  <= 1'b0;
         rd        <= '0;
         WriteData <= '0;
      end else if (a_accept && !is_x0(a_rd)) begin
         RegWrite  <= 1'b1;
         rd        <= a_rd;
         WriteData <= a_data;
      end else if (head_grant) begin
         RegWrite  <= 1'b1;
         rd        <= head_rd;
         WriteData <= head_data;
      end else begin
         RegWrite  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              a_valid;
   logic [4:0]        a_rd;
   logic [31:0]       a_data;
   logic              a_ready;
   logic              b_valid;
   logic [4:0]        b_rd;
   logic [31:0]       b_data;
   logic              b_ready;
   logic              RegWrite;
   logic [4:0]        rd;
   logic [31:0]       WriteData;
   logic [31:0]       busy_mask;

   int total;
   int bad;

   regfile_wb_arbiter #(.STARVE_MAX(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (a_valid),
      .a_rd      (a_rd),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_rd      (b_rd),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .RegWrite  (RegWrite),
      .rd        (rd),
      .WriteData (WriteData),
      .busy_mask (busy_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst_n   = 1'b0;
      a_valid = 1'b0;
      a_rd    = '0;
      a_data  = '0;
      b_valid = 1'b0;
      b_rd    = '0;
      b_data  = '0;

      // reset state
      step();
      step();
      check_val("rst_regwrite", {31'd0, RegWrite}, 32'd0);
      check_val("rst_rd", {27'd0, rd}, 32'd0);
      check_val("rst_wdata", WriteData, 32'd0);
      check_val("rst_busy", busy_mask, 32'd0);
      check_val("rst_a_ready", {31'd0, a_ready}, 32'd1);
      check_val("rst_b_ready", {31'd0, b_ready}, 32'd1);
      rst_n = 1'b1;
      step();
      check_val("post_rst_regwrite", {31'd0, RegWrite}, 32'd0);

      // A only
      a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234_5678;
      settle();
      check_val("a_ready_basic", {31'd0, a_ready}, 32'd1);
      step();
      a_valid = 1'b0;
      check_val("a_regwrite", {31'd0, RegWrite}, 32'd1);
      check_val("a_rd", {27'd0, rd}, 32'd5);
      check_val("a_wdata", WriteData, 32'h1234_5678);
      step();
      check_val("a_regwrite_drop", {31'd0, RegWrite}, 32'd0);
      check_val("a_rd_hold", {27'd0, rd}, 32'd5);

      // B only
      b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hCAFE_BABE;
      settle();
      check_val("b_ready_basic", {31'd0, b_ready}, 32'd1);
      step();
      b_valid = 1'b0;
      check_val("b_busy", busy_mask, 32'h0000_0080);
      check_val("b_no_passaround", {31'd0, RegWrite}, 32'd0);
      step();
      check_val("b_regwrite", {31'd0, RegWrite}, 32'd1);
      check_val("b_rd", {27'd0, rd}, 32'd7);
      check_val("b_wdata", WriteData, 32'hCAFE_BABE);
      check_val("b_busy_clear", busy_mask, 32'd0);
      step();
      check_val("b_regwrite_drop", {31'd0, RegWrite}, 32'd0);

      // starvation: B x3 queued, A hammers x9
      b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h0000_0033;
      step();
      b_valid = 1'b0;
      a_valid = 1'b1; a_rd = 5'd9;
      for (int i = 1; i <= 4; i++) begin
         a_data = 32'h900 + 32'(i);
         settle();
         check_val($sformatf("starve_a_ready%0d", i), {31'd0, a_ready}, 32'd1);
         step();
         check_val($sformatf("starve_a_wr%0d", i), {27'd0, rd}, 32'd9);
         check_val($sformatf("starve_a_data%0d", i), WriteData, 32'h900 + 32'(i));
      end
      a_data = 32'h905;
      settle();
      check_val("starve_a_blocked", {31'd0, a_ready}, 32'd0);
      step();
      check_val("starve_b_wr", {31'd0, RegWrite}, 32'd1);
      check_val("starve_b_rd", {27'd0, rd}, 32'd3);
      check_val("starve_b_data", WriteData, 32'h33);
      check_val("starve_busy_clear", busy_mask, 32'd0);
      settle();
      check_val("starve_a_resume", {31'd0, a_ready}, 32'd1);
      step();
      check_val("starve_a_after_rd", {27'd0, rd}, 32'd9);
      check_val("starve_a_after_data", WriteData, 32'h905);
      a_valid = 1'b0;
      step();

      // WAW: queued B x4, then A x4
      b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h0000_00B4;
      step();
      b_valid = 1'b0;
      a_valid = 1'b1; a_rd = 5'd4; a_data = 32'h1;
      settle();
      check_val("waw_busy", busy_mask, 32'h0000_0010);
      check_val("waw_a_blocked", {31'd0, a_ready}, 32'd0);
      step();
      check_val("waw_first_rd", {27'd0, rd}, 32'd4);
      check_val("waw_first_data", WriteData, 32'hB4);
      settle();
      check_val("waw_a_released", {31'd0, a_ready}, 32'd1);
      step();
      check_val("waw_second_wr", {31'd0, RegWrite}, 32'd1);
      check_val("waw_second_data", WriteData, 32'h1);
      a_valid = 1'b0;
      step();

      // x0 from A: no write, outputs hold
      a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF_FFFF;
      settle();
      check_val("x0_a_ready", {31'd0, a_ready}, 32'd1);
      step();
      a_valid = 1'b0;
      check_val("x0_a_regwrite", {31'd0, RegWrite}, 32'd0);
      check_val("x0_a_hold", WriteData, 32'h1);
      // x0 from B: acknowledged, never queued
      b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFF_FFFF;
      settle();
      check_val("x0_b_ready", {31'd0, b_ready}, 32'd1);
      step();
      b_valid = 1'b0;
      check_val("x0_b_busy", busy_mask, 32'd0);
      step();
      check_val("x0_b_regwrite", {31'd0, RegWrite}, 32'd0);

      // full: three B pushes while A keeps the port busy
      a_valid = 1'b1; a_rd = 5'd9; a_data = 32'hA0;
      b_valid = 1'b1; b_rd = 5'd10; b_data = 32'hB10;
      settle();
      check_val("full_push0_ready", {31'd0, b_ready}, 32'd1);
      step();
      b_rd = 5'd11; b_data = 32'hB11;
      settle();
      check_val("full_push1_ready", {31'd0, b_ready}, 32'd1);
      step();
      b_rd = 5'd12; b_data = 32'hB12;
      settle();
      check_val("full_busy2", busy_mask, 32'h0000_0C00);
      for (int c = 2; c <= 5; c++) begin
         settle();
         check_val($sformatf("full_b_ready_c%0d", c), {31'd0, b_ready}, 32'd0);
         check_val($sformatf("full_a_ready_c%0d", c), {31'd0, a_ready}, (c == 5) ? 32'd0 : 32'd1);
         step();
      end
      check_val("full_pop_rd", {27'd0, rd}, 32'd10);
      check_val("full_pop_data", WriteData, 32'hB10);
      settle();
      check_val("full_ready_after_pop", {31'd0, b_ready}, 32'd1);
      step();
      b_valid = 1'b0;
      a_valid = 1'b0;
      check_val("full_busy_after_push", busy_mask, 32'h0000_1800);
      step();
      check_val("full_drain1_rd", {27'd0, rd}, 32'd11);
      check_val("full_drain1_data", WriteData, 32'hB11);
      step();
      check_val("full_drain2_rd", {27'd0, rd}, 32'd12);
      check_val("full_drain2_data", WriteData, 32'hB12);
      check_val("full_drained_busy", busy_mask, 32'd0);
      step();

      // reset mid-operation with two queued entries and an A write in flight
      a_valid = 1'b1; a_rd = 5'd9; a_data = 32'hDEAD;
      b_valid = 1'b1; b_rd = 5'd20; b_data = 32'h20;
      step();
      b_rd = 5'd21; b_data = 32'h21;
      step();
      b_valid = 1'b0;
      check_val("midrst_busy_before", busy_mask, 32'h0030_0000);
      check_val("midrst_inflight", {31'd0, RegWrite}, 32'd1);
      rst_n = 1'b0;
      settle();
      check_val("midrst_regwrite", {31'd0, RegWrite}, 32'd0);
      check_val("midrst_rd", {27'd0, rd}, 32'd0);
      check_val("midrst_wdata", WriteData, 32'd0);
      check_val("midrst_busy", busy_mask, 32'd0);
      check_val("midrst_b_ready", {31'd0, b_ready}, 32'd1);
      step();
      a_valid = 1'b0;
      rst_n = 1'b1;
      step();
      check_val("midrst_release1", {31'd0, RegWrite}, 32'd0);
      step();
      check_val("midrst_release2", {31'd0, RegWrite}, 32'd0);
      check_val("midrst_busy_after", busy_mask, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
